// File: rtl/subckt_bist_pkg.sv
// Shared encodings and polynomials for the subcircuit BIST sequencer.
package subckt_bist_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_SEED  = 3'd1;
    localparam logic [2:0] ST_RUN   = 3'd2;
    localparam logic [2:0] ST_FLUSH = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [15:0] LFSR_POLY = 16'hB400;
    localparam logic [15:0] MISR_POLY = 16'h1021;

    // Galois right-shift step; a non-zero state never maps to zero.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/bist_lfsr_misr.sv
// Pattern LFSR and output-compacting MISR for the subcircuit BIST sequencer.
module bist_lfsr_misr
    import subckt_bist_pkg::*;
#(
    parameter int          N_IN      = 10,
    parameter int          SIG_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'h0001
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [15:0]      seed_i,
    input  logic             advance_i,
    input  logic             clear_i,
    input  logic             compact_i,
    input  logic             din_i,
    output logic [N_IN-1:0]  vec_o,
    output logic [SIG_W-1:0] sig_o
);

    logic [15:0]      lfsr_q, lfsr_d;
    logic [SIG_W-1:0] sig_q, sig_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load_i) begin
            // A zero seed would lock the LFSR, so it selects the default seed.
            lfsr_d = (seed_i == 16'h0000) ? LFSR_SEED : seed_i;
        end else if (advance_i) begin
            lfsr_d = lfsr_step(lfsr_q);
        end
    end

    always_comb begin
        sig_d = sig_q;
        if (clear_i) begin
            sig_d = '0;
        end else if (compact_i) begin
            sig_d = {sig_q[SIG_W-2:0], 1'b0}
                  ^ (sig_q[SIG_W-1] ? SIG_W'(MISR_POLY) : '0)
                  ^ SIG_W'(din_i);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lfsr_q <= LFSR_SEED;
            sig_q  <= '0;
        end else begin
            lfsr_q <= lfsr_d;
            sig_q  <= sig_d;
        end
    end

    assign vec_o = lfsr_q[N_IN-1:0];
    assign sig_o = sig_q;

endmodule

// File: rtl/subckt_bist_ctrl.sv
// BIST sequencer: resets the subcircuit, applies LFSR vectors, compacts its
// output into a MISR signature and compares against a golden value.
module subckt_bist_ctrl
    import subckt_bist_pkg::*;
#(
    parameter int          N_IN      = 10,
    parameter int          PAT_COUNT = 1000,
    parameter int          PIPE_LAT  = 2,
    parameter logic [15:0] LFSR_SEED = 16'h0001,
    parameter int          SIG_W     = 16,
    parameter int          RST_CYC   = 2
) (
    input  logic             I1470,
    input  logic             I1477,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      seed_in,
    input  logic [SIG_W-1:0] golden,
    output logic [N_IN-1:0]  dut_in,
    output logic             dut_rst,
    input  logic             dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature
);

    localparam int CNT_W    = $clog2(PAT_COUNT + 1);
    localparam int TMR_MAX  = (RST_CYC > PIPE_LAT) ? RST_CYC : PIPE_LAT;
    localparam int TMR_W    = $clog2(TMR_MAX + 1);
    localparam int FLUSH_LD = (PIPE_LAT > 0) ? PIPE_LAT - 1 : 0;

    logic [2:0]       state_q, state_d;
    logic             acc_q, acc_d;
    logic [15:0]      seed_q, seed_d;
    logic [SIG_W-1:0] golden_q, golden_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [CNT_W-1:0] pat_cnt_q, pat_cnt_d;
    logic [N_IN-1:0]  hold_q, hold_d;

    logic             accept, abort_eff, in_run, in_flush;
    logic             load, advance, clear, vld_out, compact;
    logic [N_IN-1:0]  vec;

    assign in_run    = (state_q == ST_RUN);
    assign in_flush  = (state_q == ST_FLUSH);
    assign abort_eff = abort && (state_q != ST_IDLE);
    // start is captured here and acted on one edge later; abort wins a tie.
    assign accept    = start && !abort && !acc_q
                    && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    always_comb begin
        state_d   = state_q;
        acc_d     = accept;
        seed_d    = accept ? seed_in : seed_q;
        golden_d  = accept ? golden  : golden_q;
        tmr_d     = tmr_q;
        pat_cnt_d = pat_cnt_q;
        hold_d    = hold_q;
        load      = 1'b0;
        advance   = 1'b0;
        clear     = 1'b0;
        if (abort_eff) begin
            state_d = ST_IDLE;
            acc_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (acc_q) begin
                        state_d   = ST_SEED;
                        tmr_d     = TMR_W'(RST_CYC - 1);
                        pat_cnt_d = '0;
                        hold_d    = '0;
                        load      = 1'b1;
                        clear     = 1'b1;
                    end
                end
                ST_SEED: begin
                    if (tmr_q == '0) state_d = ST_RUN;
                    else             tmr_d   = tmr_q - 1'b1;
                end
                ST_RUN: begin
                    advance   = 1'b1;
                    hold_d    = vec;
                    pat_cnt_d = pat_cnt_q + 1'b1;
                    if (pat_cnt_q == CNT_W'(PAT_COUNT - 1)) begin
                        state_d = (PIPE_LAT == 0) ? ST_DONE : ST_FLUSH;
                        tmr_d   = TMR_W'(FLUSH_LD);
                    end
                end
                ST_FLUSH: begin
                    if (tmr_q == '0) state_d = ST_DONE;
                    else             tmr_d   = tmr_q - 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge I1470 or posedge I1477) begin
        if (I1477) begin
            state_q   <= ST_IDLE;
            acc_q     <= 1'b0;
            seed_q    <= '0;
            golden_q  <= '0;
            tmr_q     <= '0;
            pat_cnt_q <= '0;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            seed_q    <= seed_d;
            golden_q  <= golden_d;
            tmr_q     <= tmr_d;
            pat_cnt_q <= pat_cnt_d;
            hold_q    <= hold_d;
        end
    end

    // Flags which cycles' DUT output belongs to an applied vector.
    if (PIPE_LAT == 0) begin : g_nopipe
        assign vld_out = in_run;
    end else begin : g_pipe
        logic [PIPE_LAT-1:0] vld_q, vld_d;
        always_comb begin
            vld_d = (vld_q << 1) | PIPE_LAT'(in_run);
            if (load) vld_d = '0;
        end
        always_ff @(posedge I1470 or posedge I1477) begin
            if (I1477) vld_q <= '0;
            else       vld_q <= vld_d;
        end
        assign vld_out = vld_q[PIPE_LAT-1];
    end

    assign compact = vld_out && (in_run || in_flush) && !abort_eff;

    bist_lfsr_misr #(
        .N_IN      (N_IN),
        .SIG_W     (SIG_W),
        .LFSR_SEED (LFSR_SEED)
    ) u_lfsr_misr (
        .clk_i     (I1470),
        .rst_i     (I1477),
        .load_i    (load),
        .seed_i    (seed_q),
        .advance_i (advance),
        .clear_i   (clear),
        .compact_i (compact),
        .din_i     (dut_out),
        .vec_o     (vec),
        .sig_o     (signature)
    );

    assign dut_in  = in_run ? vec : hold_q;
    assign dut_rst = !(in_run || in_flush);
    assign busy    = (state_q == ST_SEED) || in_run || in_flush;
    assign done    = (state_q == ST_DONE);
    assign pass    = done && (signature == golden_q);

endmodule

// File: tb/tb_subckt_bist_ctrl.sv
// Directed bench for subckt_bist_ctrl: table-driven runs plus abort,
// asynchronous-reset and alternative-parameter sequences.
module tb_subckt_bist_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Instance A: PAT_COUNT=4, PIPE_LAT=2, RST_CYC=2
    logic        start_a = 1'b0, abort_a = 1'b0;
    logic [15:0] seed_a = '0, golden_a = '0, sig_a;
    logic [9:0]  dut_in_a;
    logic        dut_rst_a, dut_out_a, busy_a, done_a, pass_a;
    logic [1:0]  mode_a = 2'd0;
    logic        m1 = 1'b0, m2 = 1'b0;

    // Toy two-stage subcircuit: output = in[0]^in[9], delayed two cycles.
    always @(posedge clk) begin
        if (dut_rst_a) begin
            m1 <= 1'b0;
            m2 <= 1'b0;
        end else begin
            m1 <= dut_in_a[0] ^ dut_in_a[9];
            m2 <= m1;
        end
    end
    assign dut_out_a = (mode_a == 2'd0) ? 1'b0 : (mode_a == 2'd1) ? 1'b1 : m2;

    subckt_bist_ctrl #(.PAT_COUNT(4), .PIPE_LAT(2), .RST_CYC(2)) u_a (
        .I1470(clk), .I1477(rst), .start(start_a), .abort(abort_a),
        .seed_in(seed_a), .golden(golden_a), .dut_in(dut_in_a),
        .dut_rst(dut_rst_a), .dut_out(dut_out_a), .busy(busy_a),
        .done(done_a), .pass(pass_a), .signature(sig_a)
    );

    // Instance B: PAT_COUNT=1, PIPE_LAT=0, output tied high
    logic        start_b = 1'b0, abort_b = 1'b0, one_b = 1'b1;
    logic [15:0] seed_b = '0, golden_b = 16'h0001, sig_b;
    logic [9:0]  dut_in_b;
    logic        dut_rst_b, busy_b, done_b, pass_b;

    subckt_bist_ctrl #(.PAT_COUNT(1), .PIPE_LAT(0), .RST_CYC(2)) u_b (
        .I1470(clk), .I1477(rst), .start(start_b), .abort(abort_b),
        .seed_in(seed_b), .golden(golden_b), .dut_in(dut_in_b),
        .dut_rst(dut_rst_b), .dut_out(one_b), .busy(busy_b),
        .done(done_b), .pass(pass_b), .signature(sig_b)
    );

    // Instance C: PAT_COUNT=20, PIPE_LAT=1, RST_CYC=1; exercises MISR feedback
    logic        start_c = 1'b0, abort_c = 1'b0, one_c = 1'b1;
    logic [15:0] seed_c = '0, golden_c = 16'h0E10, sig_c;
    logic [9:0]  dut_in_c;
    logic        dut_rst_c, busy_c, done_c, pass_c;

    subckt_bist_ctrl #(.PAT_COUNT(20), .PIPE_LAT(1), .RST_CYC(1)) u_c (
        .I1470(clk), .I1477(rst), .start(start_c), .abort(abort_c),
        .seed_in(seed_c), .golden(golden_c), .dut_in(dut_in_c),
        .dut_rst(dut_rst_c), .dut_out(one_c), .busy(busy_c),
        .done(done_c), .pass(pass_c), .signature(sig_c)
    );

    typedef struct {
        logic [15:0]      seed;
        logic [15:0]      golden;
        logic [1:0]       mode;
        bit               inj_start;
        logic [3:0][9:0]  vec;
        logic [15:0]      sig;
        bit               pass;
    } vec_t;

    vec_t tbl[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Start at edge 0; sample after edges 1..10.
    task automatic run_a(input vec_t r, input string tag);
        seed_a   = r.seed;
        golden_a = r.golden;
        mode_a   = r.mode;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk($sformatf("%s busy k%0d", tag, k), busy_a, (k <= 8));
            chk($sformatf("%s done k%0d", tag, k), done_a, (k >= 9));
            if (k == 2) chk($sformatf("%s dut_rst k2", tag), dut_rst_a, 1'b1);
            if (k >= 3 && k <= 6) begin
                chk($sformatf("%s dut_in k%0d", tag, k), dut_in_a, r.vec[k-3]);
                chk($sformatf("%s dut_rst k%0d", tag, k), dut_rst_a, 1'b0);
            end
            if (k == 9) begin
                chk($sformatf("%s signature", tag), sig_a, r.sig);
                chk($sformatf("%s pass", tag), pass_a, r.pass);
            end
            start_a = (r.inj_start && k == 4);
        end
    endtask

    initial begin
        int first_done;

        tbl[0] = '{16'h0000, 16'h0000, 2'd0, 1'b0,
                   {10'h100, 10'h200, 10'h000, 10'h001}, 16'h0000, 1'b1};
        tbl[1] = '{16'h0000, 16'h0001, 2'd0, 1'b0,
                   {10'h100, 10'h200, 10'h000, 10'h001}, 16'h0000, 1'b0};
        tbl[2] = '{16'h0000, 16'h000F, 2'd1, 1'b0,
                   {10'h100, 10'h200, 10'h000, 10'h001}, 16'h000F, 1'b1};
        tbl[3] = '{16'h0000, 16'h000A, 2'd2, 1'b1,
                   {10'h100, 10'h200, 10'h000, 10'h001}, 16'h000A, 1'b1};
        tbl[4] = '{16'h0003, 16'h0000, 2'd2, 1'b0,
                   {10'h300, 10'h200, 10'h001, 10'h003}, 16'h000F, 1'b0};

        #12;
        chk("reset busy", busy_a, 1'b0);
        chk("reset done", done_a, 1'b0);
        chk("reset pass", pass_a, 1'b0);
        chk("reset dut_rst", dut_rst_a, 1'b1);
        chk("reset dut_in", dut_in_a, 10'h000);
        chk("reset signature", sig_a, 16'h0000);
        @(negedge clk); rst = 1'b0;

        for (int i = 0; i < 5; i++) run_a(tbl[i], $sformatf("vec%0d", i));

        // Abort during RUN freezes the signature and returns to IDLE.
        seed_a = '0; golden_a = '0; mode_a = 2'd1;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort pre busy", busy_a, 1'b1);
        chk("abort pre signature", sig_a, 16'h0001);
        abort_a = 1'b1;
        @(negedge clk); abort_a = 1'b0;
        chk("abort busy", busy_a, 1'b0);
        chk("abort done", done_a, 1'b0);
        chk("abort pass", pass_a, 1'b0);
        chk("abort dut_rst", dut_rst_a, 1'b1);
        chk("abort signature", sig_a, 16'h0001);
        repeat (3) @(negedge clk);
        chk("abort hold signature", sig_a, 16'h0001);
        chk("abort hold done", done_a, 1'b0);
        run_a(tbl[2], "post_abort");

        // Asynchronous reset during FLUSH, between clock edges.
        seed_a = '0; golden_a = 16'h000A; mode_a = 2'd2;
        @(negedge clk); start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        repeat (7) @(negedge clk);
        chk("flush busy", busy_a, 1'b1);
        chk("flush signature", sig_a, 16'h0002);
        chk("flush dut_in hold", dut_in_a, 10'h100);
        #2 rst = 1'b1;
        #1;
        chk("async busy", busy_a, 1'b0);
        chk("async done", done_a, 1'b0);
        chk("async dut_rst", dut_rst_a, 1'b1);
        chk("async dut_in", dut_in_a, 10'h000);
        chk("async signature", sig_a, 16'h0000);
        @(negedge clk); rst = 1'b0;
        run_a(tbl[3], "post_rst");

        // PAT_COUNT=1, PIPE_LAT=0: done at edge 4, one compaction of 1.
        first_done = -1;
        @(negedge clk); start_b = 1'b1;
        @(negedge clk); start_b = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) begin
                chk("b dut_in k3", dut_in_b, 10'h001);
                chk("b dut_rst k3", dut_rst_b, 1'b0);
            end
            if (done_b && first_done < 0) first_done = k;
        end
        chk("b done edge", first_done, 32'd4);
        chk("b signature", sig_b, 16'h0001);
        chk("b pass", pass_b, 1'b1);

        // PAT_COUNT=20, PIPE_LAT=1, RST_CYC=1: done at edge 23.
        first_done = -1;
        @(negedge clk); start_c = 1'b1;
        @(negedge clk); start_c = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (done_c && first_done < 0) first_done = k;
        end
        chk("c done edge", first_done, 32'd23);
        chk("c busy", busy_c, 1'b0);
        chk("c signature", sig_c, 16'h0E10);
        chk("c pass", pass_c, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
